puf_eval_ctrl: RTL

Evaluation sequencer for the arbiter-PUF array. It accepts a challenge from a requester over a valid/ready handshake and drives the challenge bus and launch edge to the PUF. It waits for the delay lines to settle, then synchronizes and captures the response and returns it over a second valid/ready handshake. It sits between the PUF array and its consumer (host readout or DNN feature path) and replaces free-running launch timing with per-request sequencing.

---
 rtl/puf_pkg.sv | 23 ++
 rtl/puf_resp_sync.sv | 26 ++
 rtl/puf_eval_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/puf_pkg.sv
// Shared types and constants for the arbiter-PUF evaluation path.
package puf_pkg;

  localparam int unsigned DefChallengeNum = 64;
  localparam int unsigned DefResponseNum  = 8;
  // Depth of the response synchronizer; also the length of the SAMPLE phase.
  localparam int unsigned SampleCyc       = 2;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StFire,
    StSample,
    StRecover,
    StOut
  } puf_eval_state_t;

  // Clock cycles taken by one complete evaluation (setup, settle, sample, recover).
  function automatic int unsigned eval_cycles(input int unsigned setup, input int unsigned settle);
    return 2 * setup + settle + SampleCyc;
  endfunction

endpackage

// File: rtl/puf_resp_sync.sv
// Two-flop synchronizer bringing the asynchronous arbiter outputs into the clk_i domain.
module puf_resp_sync #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/puf_eval_ctrl.sv
// Per-request launch sequencer for the arbiter-PUF array with synchronized response capture.
// Define PUF_MAJORITY_VOTE_EN to run VOTES evaluations per request and return the bitwise majority.
module puf_eval_ctrl
  import puf_pkg::*;
#(
  parameter int unsigned CHALLENGE_NUM = DefChallengeNum,
  parameter int unsigned RESPONSE_NUM  = DefResponseNum,
  parameter int unsigned SETUP_CYC     = 50,
  parameter int unsigned SETTLE_CYC    = 450,
  parameter int unsigned VOTES         = 5
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [CHALLENGE_NUM-1:0] req_challenge_i,
  output logic [CHALLENGE_NUM-1:0] puf_challenge_o,
  output logic                     puf_launch_o,
  input  logic [RESPONSE_NUM-1:0]  puf_response_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [RESPONSE_NUM-1:0]  rsp_data_o,
  output logic                     busy_o,
  output logic [31:0]              eval_cnt_o
);

  localparam int unsigned MaxCyc = (SETUP_CYC > SETTLE_CYC) ? SETUP_CYC : SETTLE_CYC;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);

  localparam logic [CntW-1:0] SetupLast  = CntW'(SETUP_CYC - 1);
  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYC - 1);
  localparam logic [CntW-1:0] SampleLast = CntW'(SampleCyc - 1);

  if (SETUP_CYC < 1 || SETTLE_CYC < 1 || VOTES < 1 || (VOTES % 2) == 0) begin : gen_bad_param
    $error("puf_eval_ctrl: SETUP_CYC/SETTLE_CYC must be >= 1 and VOTES odd and >= 1");
  end

  puf_eval_state_t state_q, state_d;

  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [CHALLENGE_NUM-1:0] challenge_q, challenge_d;
  logic                     launch_q, launch_d;
  logic [RESPONSE_NUM-1:0]  rsp_data_q, rsp_data_d;
  logic [31:0]              eval_cnt_q, eval_cnt_d;
  // Holds req_ready low while reset is asserted and until the first clock afterwards.
  logic                     ready_en_q;
  logic                     more_votes;
  logic [RESPONSE_NUM-1:0]  resp_sync;

  puf_resp_sync #(
    .Width (RESPONSE_NUM)
  ) u_resp_sync (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (puf_response_i),
    .q_o    (resp_sync)
  );

`ifdef PUF_MAJORITY_VOTE_EN
  localparam int unsigned     VoteW     = $clog2(VOTES + 1);
  localparam logic [VoteW-1:0] VoteTotal = VoteW'(VOTES);
  localparam logic [VoteW-1:0] VoteHalf  = VoteW'(VOTES / 2);

  logic [VoteW-1:0]        ones_q [RESPONSE_NUM];
  logic [VoteW-1:0]        ones_d [RESPONSE_NUM];
  logic [VoteW-1:0]        vote_q, vote_d;
  logic [RESPONSE_NUM-1:0] majority;

  always_comb begin
    majority = '0;
    for (int i = 0; i < RESPONSE_NUM; i++) begin
      majority[i] = (ones_q[i] > VoteHalf);
    end
  end

  // vote_q counts completed evaluations, so this is checked after the increment.
  assign more_votes = (vote_q != VoteTotal);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ones_q <= '{default: '0};
      vote_q <= '0;
    end else begin
      ones_q <= ones_d;
      vote_q <= vote_d;
    end
  end
`else
  assign more_votes = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CntW'(1);
    challenge_d = challenge_q;
    rsp_data_d  = rsp_data_q;
    eval_cnt_d  = eval_cnt_q;
`ifdef PUF_MAJORITY_VOTE_EN
    ones_d      = ones_q;
    vote_d      = vote_q;
`endif

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (req_valid_i && req_ready_o) begin
          state_d     = StSetup;
          challenge_d = req_challenge_i;
`ifdef PUF_MAJORITY_VOTE_EN
          ones_d      = '{default: '0};
          vote_d      = '0;
`endif
        end
      end
      StSetup: begin
        if (cnt_q == SetupLast) begin
          state_d = StFire;
          cnt_d   = '0;
        end
      end
      StFire: begin
        if (cnt_q == SettleLast) begin
          state_d = StSample;
          cnt_d   = '0;
        end
      end
      StSample: begin
        if (cnt_q == SampleLast) begin
          state_d = StRecover;
          cnt_d   = '0;
`ifdef PUF_MAJORITY_VOTE_EN
          for (int i = 0; i < RESPONSE_NUM; i++) begin
            ones_d[i] = ones_q[i] + VoteW'(resp_sync[i]);
          end
          vote_d = vote_q + VoteW'(1);
`else
          rsp_data_d = resp_sync;
`endif
        end
      end
      StRecover: begin
        if (cnt_q == SetupLast) begin
          cnt_d = '0;
          if (more_votes) begin
            state_d = StSetup;
          end else begin
            state_d = StOut;
`ifdef PUF_MAJORITY_VOTE_EN
            rsp_data_d = majority;
`endif
          end
        end
      end
      StOut: begin
        cnt_d = '0;
        if (rsp_ready_i) begin
          state_d    = StIdle;
          eval_cnt_d = eval_cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // Launch is a pure flop output, decoded from the next state.
    launch_d = (state_d == StFire);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      challenge_q <= '0;
      launch_q    <= 1'b0;
      rsp_data_q  <= '0;
      eval_cnt_q  <= '0;
      ready_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      challenge_q <= challenge_d;
      launch_q    <= launch_d;
      rsp_data_q  <= rsp_data_d;
      eval_cnt_q  <= eval_cnt_d;
      ready_en_q  <= 1'b1;
    end
  end

  assign req_ready_o     = ready_en_q && (state_q == StIdle);
  assign busy_o          = (state_q != StIdle);
  assign rsp_valid_o     = (state_q == StOut);
  assign puf_challenge_o = challenge_q;
  assign puf_launch_o    = launch_q;
  assign rsp_data_o      = rsp_data_q;
  assign eval_cnt_o      = eval_cnt_q;

endmodule
